// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arb_pkg
// Purpose  : Shared types and constants for the single-port memory arbiter:
//            read-owner FSM encoding, access-owner codes and the width of
//            the fetch starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arb_pkg;

  // Width of the fetch starvation counter (saturates at all-ones).
  localparam int CTR_W = 4;

  // Whose read response is due from the memory in the current cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IRD  = 2'd1,
    S_DRD  = 2'd2
  } arb_state_t;

  // Which requester owns the memory port in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // A write completes in its grant cycle, so only reads leave a response
  // outstanding for the following cycle.
  function automatic arb_state_t next_state(owner_t own, logic we);
    case (own)
      OWN_I:   return S_IRD;
      OWN_D:   return we ? S_IDLE : S_DRD;
      default: return S_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the fetch port (I_*), data port (D_*) and memory port
//            (M_*) of the shared-memory arbiter.
// Modports : slave  - the arbiter (accepts requests, drives the memory)
//            master - the environment (requesters plus memory array)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int DBITS = 16,
  parameter int ABITS = 12
);

  logic             I_REQ;
  logic [ABITS-1:0] I_ADDR;
  logic             I_GNT;
  logic             I_STALL;
  logic             I_RVALID;
  logic [DBITS-1:0] I_RDATA;

  logic             D_REQ;
  logic             D_WE;
  logic [ABITS-1:0] D_ADDR;
  logic [DBITS-1:0] D_WDATA;
  logic             D_GNT;
  logic             D_RVALID;
  logic [DBITS-1:0] D_RDATA;

  logic [ABITS-1:0] M_ADDR;
  logic             M_WE;
  logic [DBITS-1:0] M_DIN;
  logic [DBITS-1:0] M_DOUT;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_DOUT,
    output I_GNT, I_STALL, I_RVALID, I_RDATA,
           D_GNT, D_RVALID, D_RDATA,
           M_ADDR, M_WE, M_DIN
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_DOUT,
    input  I_GNT, I_STALL, I_RVALID, I_RDATA,
           D_GNT, D_RVALID, D_RDATA,
           M_ADDR, M_WE, M_DIN
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arb_starve_ctr
// Purpose  : Saturating count of consecutive cycles the fetch port has been
//            requesting without a grant.
// Ports    : CLK    - clock
//            RESETN - asynchronous active-low reset
//            inc    - fetch requested and was denied this cycle
//            clr    - fetch granted or not requesting this cycle
//            lim    - threshold at which fetch takes priority
//            at_lim - count equals lim
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arb_starve_ctr
  import mem_port_arb_pkg::*;
(
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             inc,
  input  logic             clr,
  input  logic [CTR_W-1:0] lim,
  output logic             at_lim
);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CTR_W{1'b1}})) begin
      cnt_d = cnt_q + CTR_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_lim = (cnt_q == lim);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port synchronous memory between instruction
//            fetch (I) and data load/store (D). Same-cycle grants, D has
//            priority over I, one-cycle read data routed back to the owner
//            of the previous cycle's read. Each RDATA output holds the last
//            word it delivered.
// Ports    : CLK, RESETN (async, active-low)
//            bus (mem_port_arbiter_if.slave): I_* fetch port, D_* data
//            port, M_* memory port
// Options  : MEM_PORT_ARB_FAIRNESS_EN - when defined, a starvation counter
//            gives I priority for one cycle after STARVE_LIM denials.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int DBITS      = 16,
  parameter int ABITS      = 12,
  parameter int STARVE_LIM = 4
) (
  input  logic                CLK,
  input  logic                RESETN,
  mem_port_arbiter_if.slave   bus
);

  if ((STARVE_LIM < 1) || (STARVE_LIM > 15)) begin : g_lim_range
    $error("mem_port_arbiter: STARVE_LIM must be in 1..15");
  end

  logic             i_prio;
  logic             i_win;
  logic             d_win;
  owner_t           owner;
  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [ABITS-1:0] maddr_q;
  logic [ABITS-1:0] maddr_d;
  logic [DBITS-1:0] irdata_q;
  logic [DBITS-1:0] irdata_d;
  logic [DBITS-1:0] drdata_q;
  logic [DBITS-1:0] drdata_d;

`ifdef MEM_PORT_ARB_FAIRNESS_EN
  localparam logic [CTR_W-1:0] c_lim = CTR_W'(STARVE_LIM);

  logic at_lim;

  mem_port_arb_starve_ctr u_starve_ctr (
    .CLK    (CLK),
    .RESETN (RESETN),
    .inc    (bus.I_REQ & ~i_win),
    .clr    (~bus.I_REQ | i_win),
    .lim    (c_lim),
    .at_lim (at_lim)
  );

  // A starved fetch wins this one cycle; D simply sees no grant.
  assign i_prio = at_lim & bus.I_REQ;
`else
  assign i_prio = 1'b0;
`endif

  always_comb begin
    // Grants are forced low while reset is asserted, which also keeps M_WE low.
    d_win = RESETN & bus.D_REQ & ~i_prio;
    i_win = RESETN & bus.I_REQ & ~d_win;

    owner = OWN_NONE;
    if (d_win) begin
      owner = OWN_D;
    end else if (i_win) begin
      owner = OWN_I;
    end

    // With no owner the address is parked at its last value.
    maddr_d = maddr_q;
    case (owner)
      OWN_I:   maddr_d = bus.I_ADDR;
      OWN_D:   maddr_d = bus.D_ADDR;
      default: maddr_d = maddr_q;
    endcase

    state_d = next_state(owner, bus.D_WE);

    // RDATA is the live memory output in the response cycle and the held
    // copy at all other times.
    irdata_d = (state_q == S_IRD) ? bus.M_DOUT : irdata_q;
    drdata_d = (state_q == S_DRD) ? bus.M_DOUT : drdata_q;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= S_IDLE;
      maddr_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      maddr_q  <= maddr_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign bus.I_GNT    = i_win;
  assign bus.I_STALL  = bus.I_REQ & ~i_win;
  assign bus.D_GNT    = d_win;
  assign bus.M_WE     = d_win & bus.D_WE;
  assign bus.M_ADDR   = maddr_d;
  assign bus.M_DIN    = bus.D_WDATA;
  assign bus.I_RVALID = (state_q == S_IRD);
  assign bus.D_RVALID = (state_q == S_DRD);
  assign bus.I_RDATA  = irdata_d;
  assign bus.D_RDATA  = drdata_d;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. The driver applies
//            directed and random requests, predicts grants from the priority
//            rules and queues expected read responses; a separate monitor
//            pops the queue whenever a response is due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int DBITS      = 16;
  localparam int ABITS      = 12;
  localparam int STARVE_LIM = 4;
`ifdef MEM_PORT_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DBITS(DBITS), .ABITS(ABITS)) bus ();

  mem_port_arbiter #(
    .DBITS      (DBITS),
    .ABITS      (ABITS),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .CLK    (clk),
    .RESETN (rstn),
    .bus    (bus.slave)
  );

  // Requester stimulus
  logic             ireq, dreq, dwe;
  logic [ABITS-1:0] iaddr, daddr;
  logic [DBITS-1:0] dwdata;
  assign bus.I_REQ   = ireq;
  assign bus.I_ADDR  = iaddr;
  assign bus.D_REQ   = dreq;
  assign bus.D_WE    = dwe;
  assign bus.D_ADDR  = daddr;
  assign bus.D_WDATA = dwdata;

  function automatic logic [DBITS-1:0] init_val(logic [ABITS-1:0] a);
    if (a == 12'h100) return 16'h1234;
    return (16'(a) * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Environment memory: one-cycle read latency, write lands at the clock edge.
  logic [DBITS-1:0] mem [0:(1<<ABITS)-1];
  bit               wr  [0:(1<<ABITS)-1];
  always @(posedge clk) begin
    if (bus.M_WE) begin
      mem[bus.M_ADDR] <= bus.M_DIN;
      wr[bus.M_ADDR]  <= 1'b1;
    end
    bus.M_DOUT <= wr[bus.M_ADDR] ? mem[bus.M_ADDR] : init_val(bus.M_ADDR);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ign_cnt = 0;
  int we_cnt  = 0;
  always @(negedge clk) begin
    if (bus.I_GNT) ign_cnt <= ign_cnt + 1;
    if (bus.M_WE)  we_cnt  <= we_cnt + 1;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory contents as a sparse map, starvation as a count.
  logic [DBITS-1:0] ref_mem [int];
  function automatic logic [DBITS-1:0] ref_read(logic [ABITS-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  typedef struct {
    bit               is_d;
    logic [DBITS-1:0] data;
    int               cyc;
  } exp_t;
  exp_t q[$];

  int               starve  = 0;
  bit               i_gnt_m = 1'b0;
  bit               d_gnt_m = 1'b0;
  logic [ABITS-1:0] maddr_m = '0;

  task automatic model_and_check();
    bit   exp_i, exp_d, i_first;
    exp_t e;
    exp_i = 1'b0;
    exp_d = 1'b0;
    if (!rstn) begin
      starve  = 0;
      maddr_m = '0;
    end else begin
      i_first = FAIR && ireq && (starve == STARVE_LIM);
      exp_d   = dreq && !i_first;
      exp_i   = ireq && !exp_d;
      if (exp_d)      maddr_m = daddr;
      else if (exp_i) maddr_m = iaddr;
    end
    check("I_GNT",   32'(bus.I_GNT),   32'(exp_i));
    check("D_GNT",   32'(bus.D_GNT),   32'(exp_d));
    check("I_STALL", 32'(bus.I_STALL), 32'(ireq && !exp_i));
    check("M_WE",    32'(bus.M_WE),    32'(exp_d && dwe));
    check("M_ADDR",  32'(bus.M_ADDR),  32'(maddr_m));
    if (exp_d && dwe) check("M_DIN", 32'(bus.M_DIN), 32'(dwdata));
    if (rstn) begin
      if (exp_d && dwe) begin
        ref_mem[int'(daddr)] = dwdata;
      end else if (exp_d) begin
        e.is_d = 1'b1; e.data = ref_read(daddr); e.cyc = cyc;
        q.push_back(e);
      end
      if (exp_i) begin
        e.is_d = 1'b0; e.data = ref_read(iaddr); e.cyc = cyc;
        q.push_back(e);
      end
      if (ireq && !exp_i) starve = (starve < 15) ? starve + 1 : 15;
      else                starve = 0;
    end
    i_gnt_m = exp_i;
    d_gnt_m = exp_d;
  endtask

  task automatic tick();
    @(negedge clk);
    model_and_check();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a response is due the cycle after the grant that queued it.
  logic [DBITS-1:0] last_i = '0;
  logic [DBITS-1:0] last_d = '0;
  initial begin : monitor
    bit   due;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        check("rst_I_RVALID", 32'(bus.I_RVALID), 32'd0);
        check("rst_D_RVALID", 32'(bus.D_RVALID), 32'd0);
        check("rst_I_RDATA",  32'(bus.I_RDATA),  32'd0);
        check("rst_D_RDATA",  32'(bus.D_RDATA),  32'd0);
        q.delete();
        last_i = '0;
        last_d = '0;
      end else begin
        due    = (q.size() > 0) && (q[0].cyc < cyc);
        e.is_d = 1'b0;
        if (due) begin
          e = q.pop_front();
          check("I_RVALID", 32'(bus.I_RVALID), 32'(!e.is_d));
          check("D_RVALID", 32'(bus.D_RVALID), 32'(e.is_d));
          if (e.is_d) begin
            check("D_RDATA", 32'(bus.D_RDATA), 32'(e.data));
            last_d = e.data;
          end else begin
            check("I_RDATA", 32'(bus.I_RDATA), 32'(e.data));
            last_i = e.data;
          end
        end else begin
          check("idle_I_RVALID", 32'(bus.I_RVALID), 32'd0);
          check("idle_D_RVALID", 32'(bus.D_RVALID), 32'd0);
        end
        if (!(due && !e.is_d)) check("hold_I_RDATA", 32'(bus.I_RDATA), 32'(last_i));
        if (!(due &&  e.is_d)) check("hold_D_RDATA", 32'(bus.D_RDATA), 32'(last_d));
      end
    end
  end

  int base;

  initial begin : driver
    // Reset with both requesters active: no grants, no write may escape.
    rstn = 1'b0;
    ireq = 1'b1; iaddr = 12'h010;
    dreq = 1'b1; dwe = 1'b1; daddr = 12'h007; dwdata = 16'hFFFF;
    repeat (2) tick();
    rstn = 1'b1;
    ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
    tick();

    // Fetch only, then data held for a cycle after delivery.
    ireq = 1'b1; iaddr = 12'h100;
    tick();
    ireq = 1'b0;
    repeat (2) tick();

    // Collision: D write wins, I stalls then gets the next cycle; read back.
    ireq = 1'b1; iaddr = 12'h010;
    dreq = 1'b1; dwe = 1'b1; daddr = 12'h005; dwdata = 16'h00AB;
    tick();
    dreq = 1'b0;
    tick();
    ireq = 1'b0;
    dreq = 1'b1; dwe = 1'b0; daddr = 12'h005;
    tick();
    dreq = 1'b0;
    repeat (2) tick();

    // Sustained contention for 20 cycles.
    base = ign_cnt;
    ireq = 1'b1; iaddr = 12'h040;
    dreq = 1'b1; dwe = 1'b0; daddr = 12'h080;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (d_gnt_m) daddr = daddr + 12'd1;
      if (i_gnt_m) iaddr = iaddr + 12'd1;
    end
    check("starve_I_grants", 32'(ign_cnt - base), FAIR ? 32'd4 : 32'd0);
    ireq = 1'b0; dreq = 1'b0;
    repeat (2) tick();

    // Pipelined fetch.
    ireq = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iaddr = 12'h200 + 12'(k);
      tick();
    end
    ireq = 1'b0;
    repeat (2) tick();

    // Reset while a fetch response is outstanding.
    ireq = 1'b1; iaddr = 12'h100;
    tick();
    ireq = 1'b0;
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (3) tick();

    // Lone write: exactly one M_WE cycle, no read response.
    base = we_cnt;
    dreq = 1'b1; dwe = 1'b1; daddr = 12'h300; dwdata = 16'hBEEF;
    tick();
    dreq = 1'b0; dwe = 1'b0;
    repeat (3) tick();
    check("lone_write_M_WE_cycles", 32'(we_cnt - base), 32'd1);

    // Random traffic over a small address window to provoke read-after-write.
    for (int k = 0; k < 400; k++) begin
      if (i_gnt_m || !ireq) begin
        ireq  = ($urandom_range(0, 99) < 60);
        iaddr = 12'($urandom_range(0, 31));
      end else if ($urandom_range(0, 19) == 0) begin
        ireq = 1'b0;
      end
      if (d_gnt_m || !dreq) begin
        dreq   = ($urandom_range(0, 99) < 50);
        dwe    = ($urandom_range(0, 99) < 40);
        daddr  = 12'($urandom_range(0, 31));
        dwdata = 16'($urandom);
      end
      tick();
    end
    ireq = 1'b0; dreq = 1'b0;
    repeat (3) tick();
    check("responses_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the processor's single-port synchronous memory array. It lets the instruction-fetch stage (I) and the data load/store stage (D) share one memory port. It issues same-cycle grants and routes the one-cycle-latency read data back to the winning requester. It raises an explicit fetch stall, replacing the dual-port instruction/data memory so the core can use one block-RAM port.

## Interface
- DBITS, 16, data word width
- ABITS, 12, word-address width (memory index, byte address bits [ABITS:1])
- STARVE_LIM, 4, max consecutive cycles I may be denied while requesting (fairness build only); legal range 1..15

- CLK  in  1  single clock, all state updates on posedge
- RESETN  in  1  asynchronous, active-low reset
- I_REQ  in  1  fetch request, read-only
- I_ADDR  in  ABITS  fetch word address
- I_GNT  out  1  fetch accepted this cycle
- I_STALL  out  1  I_REQ & ~I_GNT; the core holds the PC
- I_RVALID  out  1  fetch data valid
- I_RDATA  out  DBITS  fetch data
- D_REQ  in  1  data request
- D_WE  in  1  1 = write, 0 = read; sampled with D_REQ
- D_ADDR  in  ABITS  data word address
- D_WDATA  in  DBITS  write data
- D_GNT  out  1  data request accepted this cycle; for writes, this is completion
- D_RVALID  out  1  read data valid
- D_RDATA  out  DBITS  read data
- M_ADDR  out  ABITS  to memory address
- M_WE  out  1  to memory write enable
- M_DIN  out  DBITS  to memory write data
- M_DOUT  in  DBITS  from memory; valid the cycle after the address is sampled

## Operation
- Grant logic is combinational from the current REQ inputs and the registered state. At most one GNT is high per cycle.
- Default priority: D over I.
- The winner's address and data drive M_*.
- M_WE = D_GNT & D_WE.
- With no grant, M_WE = 0 and M_ADDR holds its previous value, so the memory sees no spurious write.
- FSM holds the owner of the previous cycle's access and routes M_DOUT:
  - S_IDLE: no read outstanding
  - S_IRD: I read outstanding
  - S_DRD: D read outstanding
- Next state each cycle:
  - S_IRD if I is granted
  - S_DRD if D is granted with D_WE = 0
  - S_IDLE otherwise, including D writes
- In S_IRD: I_RVALID = 1 and I_RDATA = M_DOUT. Same rule for S_DRD with D_RVALID / D_RDATA.
- Outside its RVALID cycle, each RDATA output holds the last value it delivered (registered copy); reset value 0.
- Back-to-back grants give one response per cycle, in grant order.
- Read-after-write to the same address in consecutive cycles returns the new data. This relies on the memory's write-then-read ordering; the arbiter adds no bypass.
- Reset state:
  - FSM = S_IDLE
  - I_RVALID = D_RVALID = 0
  - I_RDATA = D_RDATA = 0
  - all GNT = 0 and M_WE = 0 while RESETN = 0
  - M_ADDR = 0
  - starvation counter = 0
- RESETN asserted with a read outstanding: the response is discarded and no RVALID is issued after release.

## Timing
- Grant latency: 0 cycles (same cycle as REQ).
- Read latency: 1 cycle. A grant in cycle t gives RVALID in t+1.
- Write: single cycle, takes effect at the end of the grant cycle.
- Requester rule: REQ, ADDR, WE and WDATA stay stable until GNT. A requester may drop REQ without a grant; no state is kept.
- Throughput: one access per cycle total.
- Fairness is per cycle. There is no multi-cycle lock.

## Configuration
- Macro: MEM_PORT_ARB_FAIRNESS_EN.
- When defined, a 4-bit saturating counter is compiled in:
  - increments each cycle I_REQ & ~I_GNT
  - clears when I is granted or I_REQ = 0
  - when the counter equals STARVE_LIM, I has priority over D for that cycle; D is denied and its request stays pending
- When undefined: strict D-over-I priority and no counter. I can starve indefinitely under continuous D_REQ.

## Structure
- Shared package mem_port_arb_pkg holds:
  - FSM state encoding (S_IDLE / S_IRD / S_DRD)
  - owner codes (OWN_NONE, OWN_I, OWN_D)
  - counter width constant (4)
- Sub-module mem_port_arb_starve_ctr: the fairness counter.
  - Ports: CLK, RESETN, inc, clr, lim, at_lim.
  - Instantiated only under MEM_PORT_ARB_FAIRNESS_EN.
- Top level contains the grant mux, FSM, M_* drive and RDATA holding registers.

## Test plan
- Fetch only: memory word 0x100 = 0x1234, I_REQ with I_ADDR = 0x100 in cycle 1. Expect I_GNT = 1 in cycle 1, I_RVALID = 1 with I_RDATA = 0x1234 in cycle 2, I_RDATA still 0x1234 in cycle 3.
- Same-cycle collision: I reads 0x010 while D writes 0x00AB to 0x005. Expect D_GNT = 1 and I_STALL = 1 in cycle 1, I granted in cycle 2. Then a D read of 0x005 returns 0x00AB.
- Sustained contention, fairness build, STARVE_LIM = 4, both REQ held 20 cycles. Expect a repeating pattern of D granted 4 cycles then I granted 1, with no D_RVALID lost. Non-fairness build: I_GNT never asserts.
- Pipelined fetch: I_REQ held with addresses 0x200, 0x201, 0x202. Expect I_RVALID for 3 consecutive cycles, data in address order.
- Reset mid-read: grant an I read in cycle t, drop RESETN in cycle t+1. Expect I_RVALID = 0, I_RDATA = 0, and no RVALID after RESETN rises.
- D write with no grant contention, then idle cycles. Expect M_WE high exactly one cycle, D_RVALID never asserted, FSM in S_IDLE.
